// File: rtl/alu_fault_injector_if.sv
// rtl/alu_fault_injector_if.sv - control/status bundle between test controller and fault injector
interface alu_fault_injector_if #(
  parameter int DLY_W = 16,
  parameter int DUR_W = 8
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [3:0]       target;
  logic [4:0]       bit_sel;
  logic [DLY_W-1:0] delay;
  logic [DUR_W-1:0] duration;
  logic             busy;
  logic             active;
  logic             done;
  logic             err;
  logic [15:0]      inj_count;

  modport master (
    output start, abort, mode, target, bit_sel, delay, duration,
    input  busy, active, done, err, inj_count
  );

  modport slave (
    input  start, abort, mode, target, bit_sel, delay, duration,
    output busy, active, done, err, inj_count
  );
endinterface

// File: rtl/alu_fault_injector.sv
// rtl/alu_fault_injector.sv - arms, delays, then corrupts one bit of one replica result
// Optional macro FAULT_INJ_LFSR_EN: target/bit chosen by a free-running 16-bit LFSR.
module alu_fault_injector #(
  parameter int WIDTH = 32,
  parameter int NREP  = 10,
  parameter int DLY_W = 16,
  parameter int DUR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_fault_injector_if.slave   ctl,
  input  logic [NREP*WIDTH-1:0] rep_in,
  output logic [NREP*WIDTH-1:0] rep_out
);

  localparam int IDX_W = $clog2(NREP*WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_INJECT
  } state_t;

  state_t           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] dcnt_q, dcnt_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       tgt_q, tgt_d;
  logic [4:0]       bsel_q, bsel_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      inj_count_q, inj_count_d;

  logic [3:0]       sel_target;
  logic [4:0]       sel_bit;
  logic             req_legal;
  logic [IDX_W-1:0] fault_idx;

`ifdef FAULT_INJ_LFSR_EN
  // Taps 16,14,13,11 in right-shift Fibonacci form.
  logic [15:0] lfsr_q;
  logic        unused_sel_ports;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_comb begin
    sel_target = 4'(int'(lfsr_q[3:0]) % NREP);
    sel_bit    = 5'(int'(lfsr_q[8:4]) % WIDTH);
    req_legal  = (ctl.mode != 2'b11);
  end

  assign unused_sel_ports = &{1'b0, ctl.target, ctl.bit_sel};
`else
  always_comb begin
    sel_target = ctl.target;
    sel_bit    = ctl.bit_sel;
    req_legal  = (ctl.mode != 2'b11) &&
                 (int'(ctl.target) < NREP) &&
                 (int'(ctl.bit_sel) < WIDTH);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      dur_q       <= '0;
      mode_q      <= '0;
      tgt_q       <= '0;
      bsel_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      inj_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      dur_q       <= dur_d;
      mode_q      <= mode_d;
      tgt_q       <= tgt_d;
      bsel_q      <= bsel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      inj_count_q <= inj_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    dur_d       = dur_q;
    mode_d      = mode_q;
    tgt_d       = tgt_q;
    bsel_d      = bsel_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    inj_count_d = inj_count_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE swallows any simultaneous start, legal or not
        if (ctl.start && !ctl.abort) begin
          if (req_legal) begin
            mode_d  = ctl.mode;
            tgt_d   = sel_target;
            bsel_d  = sel_bit;
            dur_d   = ctl.duration;
            cnt_d   = ctl.delay;
            state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_INJECT;
          dcnt_d  = dur_q;
          if (inj_count_q != 16'hFFFF) begin
            inj_count_d = inj_count_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      S_INJECT: begin
        // dcnt of zero means a permanent fault: only abort or reset ends it
        if (ctl.abort) begin
          state_d = S_IDLE;
        end else if (dcnt_q == DUR_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (dcnt_q > DUR_W'(1)) begin
          dcnt_d = dcnt_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fault_idx = IDX_W'(int'(tgt_q) * WIDTH + int'(bsel_q));

  always_comb begin
    rep_out = rep_in;
    if (state_q == S_INJECT) begin
      case (mode_q)
        2'b00:   rep_out[fault_idx] = ~rep_in[fault_idx];
        2'b01:   rep_out[fault_idx] = 1'b0;
        2'b10:   rep_out[fault_idx] = 1'b1;
        default: rep_out[fault_idx] = rep_in[fault_idx];
      endcase
    end
  end

  assign ctl.busy      = (state_q != S_IDLE);
  assign ctl.active    = (state_q == S_INJECT);
  assign ctl.done      = done_q;
  assign ctl.err       = err_q;
  assign ctl.inj_count = inj_count_q;

endmodule
